// File: rtl/sqdet_arbiter.sv
// ---------------------------------------------------------------------------
// sqdet_arbiter
//
// Shares one external serial sequence detector between NREQ requesters.
// A granted requester's FRAME_W-bit frame is latched, the detector is cleared
// for one cycle, the frame is shifted out MSB first while the detector's Mealy
// match output is counted, and a one-cycle report carries the requester index,
// the number of match cycles and the match value seen on the final bit.
//
// Configuration macro:
//   SQDET_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                            undefined -> round-robin starting after the last
//                                         granted index (default build)
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   asynchronous active-low reset
//   req         in   [NREQ]          per-requester level request
//   frame_data  in   [NREQ*FRAME_W]  requester i frame at [i*FRAME_W +: FRAME_W]
//   ack         out  [NREQ]          one-hot grant pulse, frame captured this cycle
//   busy        out                  frame in flight (CLEAR, SHIFT, REPORT)
//   det_din     out                  serial bit to the detector
//   det_rst_n   out                  active-low clear to the detector
//   det_dout    in                   detector match for the current det_din
//   done        out                  one-cycle pulse in the REPORT cycle
//   done_id     out  [$clog2(NREQ)]  requester index of the finished frame
//   hit_cnt     out  [CNT_W]         match cycles counted during the frame
//   last_hit    out                  match value on the final frame bit
// ---------------------------------------------------------------------------
module sqdet_arbiter #(
    parameter int NREQ    = 4,
    parameter int FRAME_W = 8,
    parameter int CNT_W   = $clog2(FRAME_W + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*FRAME_W-1:0]    frame_data,
    output logic [NREQ-1:0]            ack,
    output logic                       busy,
    output logic                       det_din,
    output logic                       det_rst_n,
    input  logic                       det_dout,
    output logic                       done,
    output logic [$clog2(NREQ)-1:0]    done_id,
    output logic [CNT_W-1:0]           hit_cnt,
    output logic                       last_hit
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int BIT_W = $clog2(FRAME_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_W);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SHIFT,
        REPORT
    } state_t;

    state_t              state;
    state_t              next_state;
    logic                any_req;
    logic [ID_W-1:0]     sel;
    logic [FRAME_W-1:0]  frame_reg;
    logic [BIT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    work_cnt;
    logic [CNT_W-1:0]    hit_next;
    logic [ID_W-1:0]     cur_id;
    logic [ID_W-1:0]     done_id_r;
    logic [CNT_W-1:0]    hit_cnt_r;
    logic                last_hit_r;

`ifndef SQDET_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]     last_ptr;
    logic                found;
`endif

    assign any_req = |req;

    // Requester selection. Round-robin scans upward from the slot after the
    // last grant, so a requester that stays high is only served again after
    // every other pending requester has had its turn.
`ifdef SQDET_ARB_FIXED_PRIO_EN
    always_comb begin
        sel = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel = ID_W'(i);
            end
        end
    end
`else
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[(int'(last_ptr) + k) % NREQ]) begin
                sel   = ID_W'((int'(last_ptr) + k) % NREQ);
                found = 1'b1;
            end
        end
    end

    // Last-granted pointer; resetting it to the top index hands requester 0
    // first priority out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_ptr <= ID_W'(NREQ - 1);
        end else if (state == IDLE && any_req) begin
            last_ptr <= sel;
        end
    end
`endif

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = CLEAR;
            CLEAR:   next_state = SHIFT;
            SHIFT:   if (bit_cnt == LAST_BIT) next_state = REPORT;
            REPORT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Saturating hit count including the match of the bit currently on det_din
    assign hit_next = (det_dout && work_cnt != CNT_MAX) ? work_cnt + 1'b1 : work_cnt;

    // State register and datapath. The result registers are loaded on the
    // final SHIFT edge so they are valid throughout REPORT and then hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            frame_reg  <= '0;
            bit_cnt    <= '0;
            work_cnt   <= '0;
            cur_id     <= '0;
            done_id_r  <= '0;
            hit_cnt_r  <= '0;
            last_hit_r <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        frame_reg <= frame_data[int'(sel)*FRAME_W +: FRAME_W];
                        cur_id    <= sel;
                    end
                end
                CLEAR: begin
                    bit_cnt  <= '0;
                    work_cnt <= '0;
                end
                SHIFT: begin
                    frame_reg <= {frame_reg[FRAME_W-2:0], 1'b0};
                    bit_cnt   <= bit_cnt + 1'b1;
                    work_cnt  <= hit_next;
                    if (bit_cnt == LAST_BIT) begin
                        done_id_r  <= cur_id;
                        hit_cnt_r  <= hit_next;
                        last_hit_r <= det_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs. ack is combinational so the frame is captured in the grant
    // cycle; gating with rst keeps it low while reset is held.
    assign ack       = (state == IDLE && any_req && rst) ? (NREQ'(1) << sel) : '0;
    assign busy      = (state != IDLE);
    assign done      = (state == REPORT);
    assign det_din   = (state == SHIFT) ? frame_reg[FRAME_W-1] : 1'b0;
    assign det_rst_n = rst && (state != CLEAR);
    assign done_id   = done_id_r;
    assign hit_cnt   = hit_cnt_r;
    assign last_hit  = last_hit_r;

endmodule

// File: tb/tb_sqdet_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sqdet_arbiter
//
// Self-checking bench for sqdet_arbiter (NREQ=4, FRAME_W=8). The bench plays
// the role of the requesters and of the shared detector: det_dout follows a
// per-frame hit mask (bit k = match on the k-th shifted bit). Expected
// results are queued when a frame is started and compared at done.
// ---------------------------------------------------------------------------
module tb_sqdet_arbiter;

    localparam int NREQ    = 4;
    localparam int FRAME_W = 8;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int ID_W    = $clog2(NREQ);

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NREQ-1:0]          req;
    logic [NREQ*FRAME_W-1:0]  frame_data;
    logic [NREQ-1:0]          ack;
    logic                     busy;
    logic                     det_din;
    logic                     det_rst_n;
    logic                     det_dout;
    logic                     done;
    logic [ID_W-1:0]          done_id;
    logic [CNT_W-1:0]         hit_cnt;
    logic                     last_hit;

    typedef struct {
        bit                do_reset;
        logic [NREQ-1:0]   raise;
        bit                sticky;
        logic [FRAME_W-1:0] mask;
        int                exp_id;
    } vec_t;

    typedef struct {
        int id;
        int hit;
        bit last;
    } exp_t;

    exp_t               sb[$];
    vec_t               vecs[8];
    logic [FRAME_W-1:0] frames[NREQ];
    int                 errors = 0;
    int                 checks = 0;
    int                 held_id;
    int                 held_hit;
    bit                 held_last;

    sqdet_arbiter #(.NREQ(NREQ), .FRAME_W(FRAME_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .frame_data (frame_data),
        .ack        (ack),
        .busy       (busy),
        .det_din    (det_din),
        .det_rst_n  (det_rst_n),
        .det_dout   (det_dout),
        .done       (done),
        .done_id    (done_id),
        .hit_cnt    (hit_cnt),
        .last_hit   (last_hit)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, expv, $time);
        end
    endtask

    // Holds reset for two edges, checks the forced-zero outputs, releases
    // mid-cycle so the caller continues in an IDLE cycle.
    task automatic resetDut();
        rst      = 1'b0;
        req      = '0;
        det_dout = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state",
                    32'({ack, busy, det_din, det_rst_n, done, done_id, hit_cnt, last_hit}), 32'd0);
        rst       = 1'b1;
        held_id   = 0;
        held_hit  = 0;
        held_last = 1'b0;
        sb.delete();
    endtask

    // Raises requests and waits (bounded) for the grant; returns in the
    // ack cycle, before its capturing edge.
    task automatic applyStimulus(input logic [NREQ-1:0] raise, input int exp_id,
                                 input int max_cycles, output bit ok);
        req = req | raise;
        ok  = 1'b0;
        for (int n = 0; n < max_cycles && !ok; n++) begin
            @(negedge clk);
            checkOutput("idle_cycle", 32'({busy, det_din, det_rst_n}), 32'({1'b0, 1'b0, 1'b1}));
            checkOutput("held_result", 32'({done, done_id, hit_cnt, last_hit}),
                        32'({1'b0, ID_W'(held_id), CNT_W'(held_hit), held_last}));
            if (ack != '0) begin
                checkOutput("ack_grant", 32'(ack), 32'(1 << exp_id));
                ok = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            checkOutput("ack_timeout", 32'(ack), 32'(1 << exp_id));
        end
    endtask

    // Drives one frame from CLEAR through REPORT. abort_at >= 0 asserts reset
    // in that SHIFT cycle and leaves reset held. busy_raise is OR-ed into req
    // in SHIFT cycle 1; busy_pulse is high only in SHIFT cycle 3.
    task automatic runFrame(input int id, input logic [FRAME_W-1:0] mask, input bit sticky,
                            input int abort_at, input logic [NREQ-1:0] busy_raise,
                            input logic [NREQ-1:0] busy_pulse);
        exp_t e;
        e.id   = id;
        e.hit  = $countones(mask);
        e.last = mask[FRAME_W-1];
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!sticky) req[id] = 1'b0;
        @(negedge clk);
        checkOutput("clear_cycle", 32'({ack, busy, det_din, det_rst_n, done}),
                    32'({NREQ'(0), 1'b1, 1'b0, 1'b0, 1'b0}));
        for (int k = 0; k < FRAME_W; k++) begin
            @(posedge clk);
            #1;
            det_dout = mask[k];
            if (k == 1) req = req | busy_raise;
            if (k == 3) req = req | busy_pulse;
            if (k == 4) req = req & ~busy_pulse;
            if (k == abort_at) begin
                rst = 1'b0;
                #1;
                checkOutput("reset_async",
                            32'({ack, busy, det_din, det_rst_n, done, done_id, hit_cnt, last_hit}), 32'd0);
                void'(sb.pop_back());
                det_dout  = 1'b0;
                held_id   = 0;
                held_hit  = 0;
                held_last = 1'b0;
                return;
            end
            @(negedge clk);
            checkOutput($sformatf("shift_bit%0d", k), 32'({ack, busy, det_din, det_rst_n, done}),
                        32'({NREQ'(0), 1'b1, frames[id][FRAME_W-1-k], 1'b1, 1'b0}));
        end
        @(posedge clk);
        #1;
        det_dout = 1'b0;
        @(negedge clk);
        checkOutput("report_cycle", 32'({ack, busy, det_din, det_rst_n, done}),
                    32'({NREQ'(0), 1'b1, 1'b0, 1'b1, 1'b1}));
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: done with no expected entry at %0t", $time);
        end else begin
            e = sb.pop_front();
            checkOutput("done_id", 32'(done_id), 32'(e.id));
            checkOutput("hit_cnt", 32'(hit_cnt), 32'(e.hit));
            checkOutput("last_hit", 32'(last_hit), 32'(e.last));
            held_id   = e.id;
            held_hit  = e.hit;
            held_last = e.last;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        frames[0] = 8'hA5;
        frames[1] = 8'h3C;
        frames[2] = 8'hF0;
        frames[3] = 8'h96;
        for (int i = 0; i < NREQ; i++) frame_data[i*FRAME_W +: FRAME_W] = frames[i];
        rst       = 1'b0;
        req       = '0;
        det_dout  = 1'b0;
        held_id   = 0;
        held_hit  = 0;
        held_last = 1'b0;

        // {reset first, req bits raised, keep granted req high, hit mask, expected grant}
        vecs[0] = '{1'b1, 4'b0001, 1'b0, 8'h48, 0};
        vecs[1] = '{1'b1, 4'b1111, 1'b1, 8'hFF, 0};
`ifdef SQDET_ARB_FIXED_PRIO_EN
        vecs[2] = '{1'b0, 4'b0000, 1'b1, 8'h81, 0};
        vecs[3] = '{1'b0, 4'b0000, 1'b1, 8'h00, 0};
        vecs[4] = '{1'b0, 4'b0000, 1'b1, 8'h7E, 0};
`else
        vecs[2] = '{1'b0, 4'b0000, 1'b1, 8'h81, 1};
        vecs[3] = '{1'b0, 4'b0000, 1'b1, 8'h00, 2};
        vecs[4] = '{1'b0, 4'b0000, 1'b1, 8'h7E, 3};
`endif
        vecs[5] = '{1'b0, 4'b0000, 1'b1, 8'h01, 0};
        vecs[6] = '{1'b0, 4'b1010, 1'b0, 8'hAA, 1};
        vecs[7] = '{1'b0, 4'b0000, 1'b0, 8'h0F, 3};

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].do_reset) resetDut();
            applyStimulus(vecs[i].raise, vecs[i].exp_id, 4, ok);
            if (ok) runFrame(vecs[i].exp_id, vecs[i].mask, vecs[i].sticky, -1, '0, '0);
            if (i == 5) req = '0;
        end

        // Reset on the 4th SHIFT cycle: frame dropped, outputs cleared at once
        req = '0;
        applyStimulus(4'b0001, 0, 4, ok);
        if (ok) runFrame(0, 8'hFF, 1'b0, 3, '0, '0);
        req = 4'b0001;
        @(negedge clk);
        checkOutput("reset_held",
                    32'({ack, busy, det_din, det_rst_n, done, done_id, hit_cnt, last_hit}), 32'd0);
        @(posedge clk);
        #1;
        req = 4'b0100;
        rst = 1'b1;
        applyStimulus('0, 2, 1, ok);
        if (ok) runFrame(2, 8'h3C, 1'b0, -1, '0, '0);

        // req[2] raised while busy is served right after REPORT; a short
        // req[3] pulse during busy is never granted
        applyStimulus(4'b0010, 1, 4, ok);
        if (ok) runFrame(1, 8'h55, 1'b0, -1, 4'b0100, 4'b1000);
        applyStimulus('0, 2, 1, ok);
        if (ok) runFrame(2, 8'h80, 1'b0, -1, '0, '0);
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            checkOutput("no_stale_ack", 32'({ack, busy}), 32'd0);
            @(posedge clk);
            #1;
        end

        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sqdet_arbiter.md
SQDET_ARBITER -- requirements
Module: sqdet_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one serial sequence detector; range 2..8.
REQ-002 Parameter FRAME_W, default 8: bits per frame shifted into the detector; range 2..16.
REQ-003 Parameter CNT_W, default $clog2(FRAME_W+1): width of hit_cnt.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 req  input  NREQ  per-requester frame request; level, held until the matching ack.
REQ-007 frame_data  input  NREQ*FRAME_W  requester i frame in slice [i*FRAME_W +: FRAME_W]; stable while req[i]=1.
REQ-008 ack  output  NREQ  one-hot single-cycle pulse; the frame is captured on this cycle.
REQ-009 busy  output  1  high from the cycle after ack through the REPORT cycle.
REQ-010 det_din  output  1  serial bit to the shared detector.
REQ-011 det_rst_n  output  1  active-low clear to the shared detector.
REQ-012 det_dout  input  1  Mealy match output of the detector for the current det_din.
REQ-013 done  output  1  single-cycle pulse when frame processing ends.
REQ-014 done_id  output  $clog2(NREQ)  index of the requester whose frame just finished; valid with done.
REQ-015 hit_cnt  output  CNT_W  number of cycles det_dout=1 during the frame; valid with done.
REQ-016 last_hit  output  1  det_dout value on the final frame bit; valid with done.

Function
REQ-017 FSM states: IDLE, CLEAR, SHIFT, REPORT.
REQ-018 IDLE: if any req is high, assert ack for the selected requester, latch its frame and index, and go to CLEAR; otherwise stay in IDLE.
REQ-019 Selection is round-robin: the search starts at the index after the last granted index and wraps from NREQ-1 to 0.
REQ-020 CLEAR lasts exactly 1 cycle; det_rst_n=0; next state is SHIFT; the bit counter and hit counter are set to 0.
REQ-021 SHIFT lasts exactly FRAME_W cycles; det_din = latched frame bit, MSB first; det_dout is sampled in the same cycle.
REQ-022 SHIFT: hit counter increments on det_dout=1 and saturates at FRAME_W.
REQ-023 REPORT lasts 1 cycle: done=1; done_id, hit_cnt and last_hit are driven from registers; next state is IDLE.
REQ-024 Latency: done asserts exactly FRAME_W+2 cycles after the ack cycle; the next ack comes no earlier than the cycle after REPORT.
REQ-025 det_din=0 outside SHIFT; det_rst_n = rst AND (state != CLEAR).
REQ-026 done_id, hit_cnt and last_hit hold their values until the next REPORT.
REQ-027 ack is never asserted outside IDLE; requests raised while busy wait and are not lost.
REQ-028 If req[i] drops before ack, no frame is taken from i; a req dropped during processing has no effect on the frame in flight.
REQ-029 A requester still high after its done is re-granted only after every other pending requester has been served once.

Reset
REQ-030 When rst=0 (asynchronous), go to IDLE and force ack=0, busy=0, done=0, done_id=0, hit_cnt=0, last_hit=0, det_din=0, det_rst_n=0.
REQ-031 The last-granted pointer resets to NREQ-1, so requester 0 has first priority after reset.
REQ-032 On reset during CLEAR, SHIFT or REPORT, the frame in flight is discarded without a done pulse; the first cycle after release is IDLE.

Configuration
REQ-033 Macro SQDET_ARB_FIXED_PRIO_EN: when defined, selection is fixed priority (lowest index wins) and the REQ-019, REQ-029 and REQ-031 pointer logic is removed; when undefined, round-robin per REQ-019.

Verification
REQ-034 NREQ=4, FRAME_W=8, req=4'b0001, frame0=8'hA5, det_dout high on SHIFT bits 3 and 6 -> det_din 1,0,1,0,0,1,0,1; done 10 cycles after ack; done_id=0, hit_cnt=2, last_hit=0.
REQ-035 req=4'b1111 held -> ack order 0,1,2,3,0; with macro defined -> ack always 0.
REQ-036 det_dout=1 on all 8 SHIFT bits -> hit_cnt=8, last_hit=1; det_rst_n=0 only in the CLEAR cycle.
REQ-037 rst=0 asserted on the 4th SHIFT cycle -> all outputs 0 immediately; no done pulse; after release, req=4'b0100 -> ack=4'b0100.
REQ-038 req[2] raised while busy with requester 1 -> ack[2] on the cycle after REPORT; req[3] pulsed high for 1 cycle while busy and dropped -> never acked.
